shift_execute_unit: RTL and testbench

Two-stage pipelined shift execution unit for the CPU's execute stage. It sits between the issue/operand-read logic and the writeback mux. It wraps one instance of the 32-bit combinational right shifter and adds three things around it: op decode, bit-reversal so the same shifter also does left shifts, and valid/ready handshaking. Sustains one shift per cycle under no backpressure, with a fixed two-cycle latency.

---
 rtl/shift_execute_unit.sv | 171 +++++++++++++++++
 tb/tb_shift_execute_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_execute_unit.sv
// shift_execute_unit
//   Two-stage pipelined shift unit for the execute stage. Stage A captures and
//   pre-conditions an op. Left shifts are bit-reversed so that one right shifter
//   serves SRL, SRA and SLL. Stage B holds the finished result for writeback.
//   Valid/ready handshakes on both sides give one op per cycle with a fixed
//   two-cycle latency when there is no backpressure.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous kill of every in-flight op
//   in_valid/in_ready   upstream handshake
//   op                  00 SRL, 01 SRA, 10 SLL, 11 pass-through
//   operand, shamt      value to shift and shift amount (0..31)
//   in_tag              opaque tag carried with the op
//   out_valid/out_ready downstream handshake
//   result, out_tag     shifted value and its tag

// Plain 32-bit logarithmic right shifter. Vacated bits take the value of 'fill'.
module shift_right_32 (
  input  logic [31:0] data,
  input  logic [4:0]  shamt,
  input  logic        fill,
  output logic [31:0] result
);
  logic [31:0] s;

  always_comb begin
    s = data;
    if (shamt[0]) s = {fill, s[31:1]};
    if (shamt[1]) s = {{2{fill}}, s[31:2]};
    if (shamt[2]) s = {{4{fill}}, s[31:4]};
    if (shamt[3]) s = {{8{fill}}, s[31:8]};
    if (shamt[4]) s = {{16{fill}}, s[31:16]};
    result = s;
  end
endmodule

module shift_execute_unit #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [31:0]      operand,
  input  logic [4:0]       shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {
    OP_SRL  = 2'b00,
    OP_SRA  = 2'b01,
    OP_SLL  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  function automatic logic [31:0] bit_rev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  op_e op_dec;
  assign op_dec = op_e'(op);

  // Stage A
  logic             a_valid_q, a_valid_d;
  logic [31:0]      a_data_q,  a_data_d;
  logic [4:0]       a_shamt_q, a_shamt_d;
  logic             a_fill_q,  a_fill_d;
  logic             a_rev_q,   a_rev_d;
  logic [TAG_W-1:0] a_tag_q,   a_tag_d;
  // Stage B
  logic             b_valid_q,  b_valid_d;
  logic [31:0]      b_result_q, b_result_d;
  logic [TAG_W-1:0] b_tag_q,    b_tag_d;

  logic        b_adv;
  logic        accept;
  logic [31:0] sh_out;

  // B can take a new value when empty or when its current one leaves this edge;
  // A can then always move into B, so in_ready follows out_ready combinationally.
  assign b_adv    = !b_valid_q | out_ready;
  assign in_ready = !a_valid_q | b_adv;
  assign accept   = in_valid & in_ready;

  shift_right_32 u_shr (
    .data   (a_data_q),
    .shamt  (a_shamt_q),
    .fill   (a_fill_q),
    .result (sh_out)
  );

  always_comb begin
    // NOTE: every _d starts as its _q (hold), so no path leaves a variable
    // unassigned and no latch is inferred.
    a_valid_d  = a_valid_q;
    a_data_d   = a_data_q;
    a_shamt_d  = a_shamt_q;
    a_fill_d   = a_fill_q;
    a_rev_d    = a_rev_q;
    a_tag_d    = a_tag_q;
    b_valid_d  = b_valid_q;
    b_result_d = b_result_q;
    b_tag_d    = b_tag_q;

    if (in_ready) a_valid_d = in_valid;

    // Data registers only toggle on a real accept; the valid bit qualifies them.
    if (accept) begin
      a_rev_d   = (op_dec == OP_SLL);
      a_data_d  = (op_dec == OP_SLL) ? bit_rev(operand) : operand;
      a_fill_d  = (op_dec == OP_SRA) & operand[31];
      a_shamt_d = (op_dec == OP_PASS) ? 5'd0 : shamt;
      a_tag_d   = in_tag;
    end

    if (b_adv) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        b_result_d = a_rev_q ? bit_rev(sh_out) : sh_out;
        b_tag_d    = a_tag_q;
      end
    end

    // Flush overrides both accept and advance.
    if (flush) begin
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
    end
  end

  // NOTE: data and tag registers are reset too, so result/out_tag read 0
  // out of reset instead of X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q  <= 1'b0;
      a_data_q   <= '0;
      a_shamt_q  <= '0;
      a_fill_q   <= 1'b0;
      a_rev_q    <= 1'b0;
      a_tag_q    <= '0;
      b_valid_q  <= 1'b0;
      b_result_q <= '0;
      b_tag_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      a_valid_q  <= a_valid_d;
      a_data_q   <= a_data_d;
      a_shamt_q  <= a_shamt_d;
      a_fill_q   <= a_fill_d;
      a_rev_q    <= a_rev_d;
      a_tag_q    <= a_tag_d;
      b_valid_q  <= b_valid_d;
      b_result_q <= b_result_d;
      b_tag_q    <= b_tag_d;
    end
  end

  assign out_valid = b_valid_q;
  assign result    = b_result_q;
  assign out_tag   = b_tag_q;

endmodule

// File: tb/tb_shift_execute_unit.sv
// Self-checking bench for shift_execute_unit: directed reset, basic, boundary,
// backpressure and flush steps, then randomized traffic against a behavioural
// shift model and an in-order expected-result queue.
module tb_shift_execute_unit;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [31:0]      operand;
  logic [4:0]       shamt;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      result;
  logic [TAG_W-1:0] out_tag;

  shift_execute_unit #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand   (operand),
    .shamt     (shamt),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    int               acc_cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          starve = 0;
  bit          exact_lat = 1'b0;
  bit          last_accept;
  bit          smp_in_ready;
  logic [31:0] cur_exp;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Reference model: the shift rules written as plain arithmetic.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] v,
                                        input logic [4:0] s);
    case (o)
      2'b00:   return v >> s;
      2'b01:   return $unsigned($signed(v) >>> s);
      2'b10:   return v << s;
      default: return v;
    endcase
  endfunction

  // One clock: inputs were set just after the previous edge; the DUT is
  // observed at the falling edge, the scoreboard updated, then the edge taken.
  task automatic cycle();
    @(negedge clk);
    smp_in_ready = in_ready;
    if (out_valid) begin
      starve = 0;
      if (sb.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("result", result, sb[0].res);
        check("out_tag", 32'(out_tag), 32'(sb[0].tag));
        if (exact_lat) check("latency", 32'(cyc - sb[0].acc_cyc), 32'd2);
        else check("latency_min", 32'(cyc - sb[0].acc_cyc >= 2), 32'd1);
        if (out_ready) void'(sb.pop_front());
      end
    end else if (sb.size() != 0) begin
      starve++;
      check("pipeline_gap", 32'(starve <= 1), 32'd1);
    end else begin
      starve = 0;
    end
    last_accept = in_valid & in_ready & !flush;
    if (flush) begin
      sb.delete();
      starve = 0;
    end
    if (last_accept) sb.push_back('{cur_exp, in_tag, cyc});
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [1:0] o, input logic [31:0] v, input logic [4:0] s,
                      input logic [TAG_W-1:0] t, input logic [31:0] exp);
    int n;
    in_valid = 1'b1; op = o; operand = v; shamt = s; in_tag = t; cur_exp = exp;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_accept && n < 50);
    if (!last_accept) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      cycle();
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; op = 2'b00; operand = 32'hFFFF_FFFF; shamt = 5'd1; in_tag = 5'd3;
    cur_exp = '0;

    // Reset with an op offered.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (3) cycle();
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Basic back-to-back ops, exact two-cycle latency.
    exact_lat = 1'b1;
    send(2'b00, 32'h8000_0000, 5'd4,  5'd1, 32'h0800_0000);
    send(2'b01, 32'h8000_0000, 5'd4,  5'd2, 32'hF800_0000);
    send(2'b10, 32'h0000_0001, 5'd31, 5'd3, 32'h8000_0000);
    send(2'b11, 32'h1234_5678, 5'd7,  5'd4, 32'h1234_5678);
    // Boundaries.
    send(2'b01, 32'h7FFF_FFFF, 5'd31, 5'd5, 32'h0000_0000);
    send(2'b01, 32'hFFFF_FFFF, 5'd31, 5'd6, 32'hFFFF_FFFF);
    for (int o = 0; o < 4; o++)
      send(2'(o), 32'hDEAD_BEEF, 5'd0, 5'(7 + o), 32'hDEAD_BEEF);
    drain();
    exact_lat = 1'b0;

    // Backpressure: two accepts fill A and B, then in_ready stays low.
    out_ready = 1'b0;
    send(2'b00, 32'hF0F0_F0F0, 5'd8, 5'd16, 32'h00F0_F0F0);
    send(2'b10, 32'h0000_00FF, 5'd8, 5'd17, 32'h0000_FF00);
    in_valid = 1'b1; op = 2'b01; operand = 32'h8000_0001; shamt = 5'd1; in_tag = 5'd18;
    cur_exp = 32'hC000_0000;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_in_ready", 32'(smp_in_ready), 32'd0);
    end
    out_ready = 1'b1;
    send(2'b01, 32'h8000_0001, 5'd1, 5'd18, 32'hC000_0000);
    send(2'b00, 32'hFFFF_FFFF, 5'd31, 5'd19, 32'h0000_0001);
    send(2'b10, 32'h8000_0001, 5'd1, 5'd20, 32'h0000_0002);
    drain();

    // Flush with two ops in flight and a third offered during the flush.
    out_ready = 1'b0;
    send(2'b00, 32'h0000_1000, 5'd4, 5'd21, 32'h0000_0100);
    send(2'b00, 32'h0000_2000, 5'd4, 5'd22, 32'h0000_0200);
    flush = 1'b1;
    in_valid = 1'b1; op = 2'b11; operand = 32'hBAD0_BAD0; shamt = 5'd0; in_tag = 5'd31;
    cur_exp = 32'hBAD0_BAD0;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    cycle();
    check("flush_dropped", 32'(out_valid), 32'd0);
    exact_lat = 1'b1;
    send(2'b10, 32'h0000_0003, 5'd4, 5'd23, 32'h0000_0030);
    drain();
    exact_lat = 1'b0;

    // Randomized traffic with random valid and backpressure.
    for (int i = 0; i < 10000; i++) begin
      if (!(in_valid && !last_accept)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        op       = 2'($urandom_range(0, 3));
        operand  = $urandom;
        case ($urandom_range(0, 7))
          0:       shamt = 5'd0;
          1:       shamt = 5'd31;
          default: shamt = 5'($urandom_range(0, 31));
        endcase
        in_tag  = TAG_W'($urandom_range(0, 31));
        cur_exp = model(op, operand, shamt);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
